// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: freezes the pipeline with mem_stall
// while an access is outstanding and flags requests that assert both read and write.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_reIn,
  input  logic        mem_weIn,
  input  logic [15:0] dst_dataIn,
  input  logic [15:0] mem_dataIn,
  output logic [15:0] mem_rd_data,
  output logic        mem_stall,
  output logic        mem_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                req;
  logic                access_now;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                op_write_q;
  logic [15:0]         mem_array [DEPTH];
  logic                unused_addr_hi;

  assign req            = mem_reIn | mem_weIn;
  assign access_now     = (state == BUSY) && (cnt == 4'd0);
  assign unused_addr_hi = ^dst_dataIn[15:ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // In DONE the inputs still show the finished instruction, so req is deliberately ignored there.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = req;
      BUSY:    mem_stall = 1'b1;
      DONE:    mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
  end

  // Request is captured in IDLE so BUSY never looks at the (possibly changing) inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 4'd0;
      mem_rd_data  <= 16'h0000;
      mem_conflict <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      op_write_q   <= 1'b0;
    end else begin
      mem_conflict <= (state == IDLE) && mem_reIn && mem_weIn;
      if ((state == IDLE) && req) begin
        addr_q     <= dst_dataIn[ADDR_W-1:0];
        wdata_q    <= mem_dataIn;
        op_write_q <= mem_weIn;
        cnt        <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access_now && !op_write_q)
        mem_rd_data <= mem_array[addr_q];
    end
  end

  // Array has no reset; a reset on the completing edge must still suppress the write.
  always_ff @(posedge clk) begin
    if (!rst && access_now && op_write_q)
      mem_array[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance at LATENCY=3 and one at
// LATENCY=1 for the back-to-back case.
module tb_dmem_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst;

  logic        mem_reIn, mem_weIn;
  logic [15:0] dst_dataIn, mem_dataIn;
  logic [15:0] mem_rd_data;
  logic        mem_stall, mem_conflict;

  logic        b_re, b_we;
  logic [15:0] b_addr, b_data;
  logic [15:0] b_rd;
  logic        b_stall, b_conflict;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .mem_reIn(mem_reIn), .mem_weIn(mem_weIn),
    .dst_dataIn(dst_dataIn), .mem_dataIn(mem_dataIn),
    .mem_rd_data(mem_rd_data), .mem_stall(mem_stall), .mem_conflict(mem_conflict)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .mem_reIn(b_re), .mem_weIn(b_we),
    .dst_dataIn(b_addr), .mem_dataIn(b_data),
    .mem_rd_data(b_rd), .mem_stall(b_stall), .mem_conflict(b_conflict)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Drives one access on dut_a starting just after a rising edge while it is IDLE, follows it
  // to DONE, checks stall length, read data and conflict pulses, then releases the inputs.
  task automatic applyStimulus(input string tag, input logic re, input logic we,
                               input logic [15:0] addr, input logic [15:0] data,
                               input logic [15:0] exp_rd, input int exp_conflict);
    int stall_cycles  = 0;
    int conflict_seen = 0;
    bit done          = 1'b0;
    mem_reIn   = re;
    mem_weIn   = we;
    dst_dataIn = addr;
    mem_dataIn = data;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_conflict) conflict_seen++;
      if (mem_stall) begin
        stall_cycles++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    checkOutput({tag, "_stall"}, 16'(stall_cycles), 16'(LAT_A + 1));
    checkOutput({tag, "_rd"}, mem_rd_data, exp_rd);
    checkOutput({tag, "_conflict"}, 16'(conflict_seen), 16'(exp_conflict));
    @(posedge clk); #1;
    mem_reIn   = 1'b0;
    mem_weIn   = 1'b0;
    dst_dataIn = 16'h0000;
    mem_dataIn = 16'h0000;
  endtask

  // One LATENCY=1 access on dut_b; inputs stay asserted so the next call follows immediately.
  task automatic applyBurst(input string tag, input logic re, input logic we,
                            input logic [15:0] addr, input logic [15:0] data,
                            input logic [15:0] exp_rd);
    b_re   = re;
    b_we   = we;
    b_addr = addr;
    b_data = data;
    @(negedge clk);
    checkOutput({tag, "_stall0"}, 16'(b_stall), 16'h0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_stall1"}, 16'(b_stall), 16'h0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_stall2"}, 16'(b_stall), 16'h0000);
    checkOutput({tag, "_rd"}, b_rd, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    mem_reIn   = 1'b0;  mem_weIn   = 1'b0;
    dst_dataIn = 16'h0; mem_dataIn = 16'h0;
    b_re       = 1'b0;  b_we       = 1'b0;
    b_addr     = 16'h0; b_data     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_stall", 16'(mem_stall), 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rd", mem_rd_data, 16'h0000);
    checkOutput("reset_conflict", 16'(mem_conflict), 16'h0000);
    checkOutput("reset_b_stall", 16'(b_stall), 16'h0000);
    @(posedge clk); #1;

    $display("[TB] basic write then read");
    applyStimulus("t1_wr", 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 0);
    applyStimulus("t1_rd", 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0);

    $display("[TB] distinct addresses, data held across writes");
    applyStimulus("t2_wr1", 1'b0, 1'b1, 16'h0001, 16'h1111, 16'hBEEF, 0);
    applyStimulus("t2_wr2", 1'b0, 1'b1, 16'h0002, 16'h2222, 16'hBEEF, 0);
    applyStimulus("t2_rd1", 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h1111, 0);
    applyStimulus("t2_wr3", 1'b0, 1'b1, 16'h0004, 16'h7777, 16'h1111, 0);
    applyStimulus("t2_rd2", 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, 0);

    $display("[TB] conflicting request");
    applyStimulus("t3_conf", 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h2222, 1);
    applyStimulus("t3_rd", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 0);

    $display("[TB] reset during a write");
    applyStimulus("t4_pre", 1'b0, 1'b1, 16'h0020, 16'h0BAD, 16'h1234, 0);
    mem_weIn = 1'b1; dst_dataIn = 16'h0020; mem_dataIn = 16'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_weIn = 1'b0; dst_dataIn = 16'h0; mem_dataIn = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_abort_stall", 16'(mem_stall), 16'h0000);
    checkOutput("t4_abort_rd", mem_rd_data, 16'h0000);
    @(posedge clk); #1;
    applyStimulus("t4_rd", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0BAD, 0);
    mem_weIn = 1'b1; dst_dataIn = 16'h0020; mem_dataIn = 16'hCCCC;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mem_weIn = 1'b0; dst_dataIn = 16'h0; mem_dataIn = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_late_stall", 16'(mem_stall), 16'h0000);
    @(posedge clk); #1;
    applyStimulus("t4_rd_late", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0BAD, 0);

    $display("[TB] address wrap");
    applyStimulus("t5_wr", 1'b0, 1'b1, 16'h0403, 16'h5555, 16'h0BAD, 0);
    applyStimulus("t5_rd", 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h5555, 0);
    applyStimulus("t5_rd_hi", 1'b1, 1'b0, 16'hFC05, 16'h0000, 16'hBEEF, 0);

    $display("[TB] back-to-back accesses at LATENCY=1");
    applyBurst("t6_wr0", 1'b0, 1'b1, 16'h0031, 16'hB001, 16'h0000);
    applyBurst("t6_wr1", 1'b0, 1'b1, 16'h0032, 16'hB002, 16'h0000);
    applyBurst("t6_wr2", 1'b0, 1'b1, 16'h0033, 16'hB003, 16'h0000);
    applyBurst("t6_wr3", 1'b0, 1'b1, 16'h0034, 16'hB004, 16'h0000);
    b_we = 1'b0;
    @(posedge clk); #1;
    applyBurst("t6_rd0", 1'b1, 1'b0, 16'h0031, 16'h0000, 16'hB001);
    applyBurst("t6_rd1", 1'b1, 1'b0, 16'h0032, 16'h0000, 16'hB002);
    applyBurst("t6_rd2", 1'b1, 1'b0, 16'h0033, 16'h0000, 16'hB003);
    applyBurst("t6_rd3", 1'b1, 1'b0, 16'h0034, 16'h0000, 16'hB004);
    b_re = 1'b0; b_addr = 16'h0;
    @(negedge clk);
    checkOutput("t6_tail_stall", 16'(b_stall), 16'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t6_tail_stall2", 16'(b_stall), 16'h0000);
    checkOutput("t6_tail_rd", b_rd, 16'hB004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
